// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch condition evaluator with status register and next-PC/link strobes
//
// Purpose:
//   Holds the ALU status flags {zero,negative,overflow} in a status register.
//   Accepts one branch request at a time from the decoder (IDLE -> EVAL -> COMMIT).
//   Evaluates B/BEQ/BNE/BLT/BLE against the registered flags.
//   Issues a one-cycle next-PC load and an optional R7 link write.
//
// Ports:
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   status_in/status_load ALU flags [2]=Z [1]=N [0]=V and their write enable
//   br_valid/br_ready     request handshake; ready only in IDLE
//   br_cond/br_link       condition code (000 B,001 BEQ,010 BNE,011 BLT,100 BLE) and link flag
//   br_pc/br_imm          branch instruction PC and signed offset
//   pc_out/pc_load/taken  next PC, its one-cycle load strobe, and the branch decision
//   link_out/link_write   zero-extended return address and its one-cycle R7 write strobe
//   status_q              current status register
//   taken_cnt/not_taken_cnt  saturating commit counters, present only with BRANCH_STATS_EN
//
// Configuration macro: BRANCH_STATS_EN
module branch_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       status_in,
  input  logic             status_load,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_link,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [IMM_W-1:0] br_imm,
  output logic [PC_W-1:0]  pc_out,
  output logic             pc_load,
  output logic             taken,
  output logic [15:0]      link_out,
  output logic             link_write,
  output logic [2:0]       status_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      taken_cnt,
  output logic [15:0]      not_taken_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       status_d;
  logic [2:0]       cond_q, cond_d;
  logic             link_q, link_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]  pc_out_q, pc_out_d;
  logic             pc_load_q, pc_load_d;
  logic             taken_q, taken_d;
  logic [15:0]      link_out_q, link_out_d;
  logic             link_write_q, link_write_d;

  logic             decide;
  logic [PC_W-1:0]  fallthrough;
  logic [PC_W-1:0]  target;

  // Decision uses the registered flags, so a status_load on the accept edge
  // is visible here while one during EVAL only affects later branches.
  always_comb begin
    decide = 1'b0;
    case (cond_q)
      3'b000:  decide = 1'b1;
      3'b001:  decide = status_q[2];
      3'b010:  decide = ~status_q[2];
      3'b011:  decide = status_q[1] ^ status_q[0];
      3'b100:  decide = (status_q[1] ^ status_q[0]) | status_q[2];
      default: decide = 1'b0;
    endcase
  end

  assign fallthrough = pc_q + PC_W'(1);
  assign target      = fallthrough + {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  always_comb begin
    state_d      = state_q;
    status_d     = status_load ? status_in : status_q;
    cond_d       = cond_q;
    link_d       = link_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    pc_out_d     = pc_out_q;
    taken_d      = taken_q;
    link_out_d   = link_out_q;
    pc_load_d    = 1'b0;
    link_write_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          cond_d  = br_cond;
          link_d  = br_link;
          pc_d    = br_pc;
          imm_d   = br_imm;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d      = decide;
        pc_out_d     = decide ? target : fallthrough;
        link_out_d   = {{(16-PC_W){1'b0}}, fallthrough};
        // Strobes are registered so they are high exactly during COMMIT.
        pc_load_d    = 1'b1;
        link_write_d = link_q & decide;
        state_d      = S_COMMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      status_q     <= 3'b000;
      cond_q       <= 3'b000;
      link_q       <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      pc_out_q     <= '0;
      pc_load_q    <= 1'b0;
      taken_q      <= 1'b0;
      link_out_q   <= 16'h0000;
      link_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      cond_q       <= cond_d;
      link_q       <= link_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      pc_out_q     <= pc_out_d;
      pc_load_q    <= pc_load_d;
      taken_q      <= taken_d;
      link_out_q   <= link_out_d;
      link_write_q <= link_write_d;
    end
  end

  assign br_ready   = (state_q == S_IDLE);
  assign pc_out     = pc_out_q;
  assign pc_load    = pc_load_q;
  assign taken      = taken_q;
  assign link_out   = link_out_q;
  assign link_write = link_write_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (state_q == S_COMMIT) begin
      if (taken_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
      end else begin
        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_d = not_taken_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      taken_cnt_q     <= 16'h0000;
      not_taken_cnt_q <= 16'h0000;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  status_in;
  logic        status_load;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic        br_link;
  logic [8:0]  br_pc;
  logic [7:0]  br_imm;
  logic [8:0]  pc_out;
  logic        pc_load;
  logic        taken;
  logic [15:0] link_out;
  logic        link_write;
  logic [2:0]  status_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_unit #(.PC_W(9), .IMM_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .status_in   (status_in),
    .status_load (status_load),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_cond     (br_cond),
    .br_link     (br_link),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .pc_out      (pc_out),
    .pc_load     (pc_load),
    .taken       (taken),
    .link_out    (link_out),
    .link_write  (link_write),
    .status_q    (status_q)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_status(input logic [2:0] s);
    @(negedge clk);
    status_in   = s;
    status_load = 1'b1;
    @(negedge clk);
    status_load = 1'b0;
    check("status_q", 32'(status_q), 32'(s));
  endtask

  // Issue one branch and check the full IDLE/EVAL/COMMIT sequence.
  // sl/sv optionally load new flags on the accept edge.
  task automatic branch(input string tag, input logic [2:0] cond, input logic lnk,
                        input logic [8:0] pc, input logic [7:0] imm,
                        input logic sl, input logic [2:0] sv,
                        input logic exp_taken, input logic [8:0] exp_pc,
                        input logic [15:0] exp_link, input logic exp_lw);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!br_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!br_ready) check({tag, " ready_timeout"}, 32'(br_ready), 32'd1);
    br_valid    = 1'b1;
    br_cond     = cond;
    br_link     = lnk;
    br_pc       = pc;
    br_imm      = imm;
    status_in   = sv;
    status_load = sl;
    @(negedge clk);
    br_valid    = 1'b0;
    status_load = 1'b0;
    check({tag, " eval_pc_load"}, 32'(pc_load), 32'd0);
    check({tag, " eval_ready"}, 32'(br_ready), 32'd0);
    @(negedge clk);
    check({tag, " pc_load"}, 32'(pc_load), 32'd1);
    check({tag, " taken"}, 32'(taken), 32'(exp_taken));
    check({tag, " pc_out"}, 32'(pc_out), 32'(exp_pc));
    check({tag, " link_out"}, 32'(link_out), 32'(exp_link));
    check({tag, " link_write"}, 32'(link_write), 32'(exp_lw));
    @(negedge clk);
    check({tag, " pc_load_drop"}, 32'(pc_load), 32'd0);
    check({tag, " link_write_drop"}, 32'(link_write), 32'd0);
    check({tag, " pc_out_hold"}, 32'(pc_out), 32'(exp_pc));
  endtask

  logic [2:0] ready_exp;

  initial begin
    reset_n     = 1'b0;
    status_in   = 3'b000;
    status_load = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'b000;
    br_link     = 1'b0;
    br_pc       = 9'd0;
    br_imm      = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_status_q", 32'(status_q), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_br_ready", 32'(br_ready), 32'd1);
    reset_n = 1'b1;

    // BEQ taken on Z
    set_status(3'b100);
    branch("beq_z", 3'b001, 1'b0, 9'd10, 8'd5, 1'b0, 3'b000, 1'b1, 9'd16, 16'd11, 1'b0);

    // BNE / BEQ with flags clear, negative offset
    set_status(3'b000);
    branch("bne", 3'b010, 1'b0, 9'd10, 8'hFD, 1'b0, 3'b000, 1'b1, 9'd8, 16'd11, 1'b0);
    branch("beq_nt", 3'b001, 1'b0, 9'd10, 8'hFD, 1'b0, 3'b000, 1'b0, 9'd11, 16'd11, 1'b0);

    // Signed comparisons
    set_status(3'b010);
    branch("blt_n", 3'b011, 1'b0, 9'd100, 8'd4, 1'b0, 3'b000, 1'b1, 9'd105, 16'd101, 1'b0);
    set_status(3'b011);
    branch("blt_nv", 3'b011, 1'b0, 9'd100, 8'd4, 1'b0, 3'b000, 1'b0, 9'd101, 16'd101, 1'b0);
    branch("ble_nv", 3'b100, 1'b0, 9'd100, 8'd4, 1'b0, 3'b000, 1'b0, 9'd101, 16'd101, 1'b0);
    set_status(3'b100);
    branch("ble_z", 3'b100, 1'b0, 9'd100, 8'd4, 1'b0, 3'b000, 1'b1, 9'd105, 16'd101, 1'b0);

    // Link and wrap-around
    branch("b_link_wrap", 3'b000, 1'b1, 9'h1FF, 8'd0, 1'b0, 3'b000, 1'b1, 9'd0, 16'h0000, 1'b1);
    branch("b_neg_wrap", 3'b000, 1'b0, 9'd0, 8'hFF, 1'b0, 3'b000, 1'b1, 9'd0, 16'd1, 1'b0);
    set_status(3'b000);
    branch("beq_link_nt", 3'b001, 1'b1, 9'd50, 8'd2, 1'b0, 3'b000, 1'b0, 9'd51, 16'd51, 1'b0);

    // Flags loaded on the accept edge are used by that branch
    branch("beq_same_edge", 3'b001, 1'b0, 9'd30, 8'd1, 1'b1, 3'b100, 1'b1, 9'd32, 16'd31, 1'b0);

    // Continuous br_valid: ready pattern 1,0,0,1,0,0; reserved cond not taken
    @(negedge clk);
    br_valid = 1'b1;
    br_cond  = 3'b111;
    br_link  = 1'b1;
    br_pc    = 9'd5;
    br_imm   = 8'd7;
    ready_exp = 3'b100;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ready_pat%0d", i), 32'(br_ready), 32'(ready_exp[2 - (i % 3)]));
      if (i % 3 == 2) begin
        check("rsv_taken", 32'(taken), 32'd0);
        check("rsv_pc_out", 32'(pc_out), 32'd6);
        check("rsv_link_write", 32'(link_write), 32'd0);
      end
      if (i == 5) br_valid = 1'b0;
      @(negedge clk);
    end

    // Reset while in EVAL: no strobe, outputs cleared
    br_valid = 1'b1;
    br_cond  = 3'b000;
    br_link  = 1'b1;
    br_pc    = 9'd20;
    br_imm   = 8'd3;
    @(negedge clk);
    br_valid = 1'b0;
    check("rst_eval_state", 32'(br_ready), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_eval_pc_load", 32'(pc_load), 32'd0);
    check("rst_eval_link_write", 32'(link_write), 32'd0);
    check("rst_eval_pc_out", 32'(pc_out), 32'd0);
    check("rst_eval_link_out", 32'(link_out), 32'd0);
    check("rst_eval_status", 32'(status_q), 32'd0);
    check("rst_eval_ready", 32'(br_ready), 32'd1);
`ifdef BRANCH_STATS_EN
    check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    check("rst_not_taken_cnt", 32'(not_taken_cnt), 32'd0);
`endif
    @(negedge clk);
    check("rst_eval_no_strobe", 32'(pc_load), 32'd0);
    reset_n = 1'b1;
    branch("post_rst_bne", 3'b010, 1'b0, 9'd2, 8'd3, 1'b0, 3'b000, 1'b1, 9'd6, 16'd3, 1'b0);
`ifdef BRANCH_STATS_EN
    check("taken_cnt", 32'(taken_cnt), 32'd1);
    check("not_taken_cnt", 32'(not_taken_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
